// File: rtl/load_store_buffer_pkg.sv
// Shared encodings for the load/store buffer: funct3 widths, Cache access codes,
// the IO address predicate and the issue FSM states.
package load_store_buffer_pkg;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    typedef enum logic [1:0] {
        ACCESS_NONE = 2'b00,
        ACCESS_BYTE = 2'b01,
        ACCESS_HALF = 2'b10,
        ACCESS_WORD = 2'b11
    } accessCode_e;

    // The IO window is every address whose bits [17:16] are both set.
    localparam logic [31:0] IO_MASK = 32'h0003_0000;

    function automatic logic isIoAddr(input logic [31:0] addr);
        return (addr & IO_MASK) == IO_MASK;
    endfunction

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_WAIT = 1'b1
    } lsbState_e;

endpackage

// File: rtl/load_store_buffer_if.sv
// Data-port bundle between the load/store buffer (master) and Cache (slave).
interface load_store_buffer_if;

    logic [1:0]  accessType;
    logic        readWriteIn;
    logic [31:0] dataAddrIn;
    logic [31:0] dataIn;
    logic        dataOutValid;
    logic [31:0] dataOut;
    logic        dataWriteSuc;

    modport master (
        output accessType, readWriteIn, dataAddrIn, dataIn,
        input  dataOutValid, dataOut, dataWriteSuc
    );

    modport slave (
        input  accessType, readWriteIn, dataAddrIn, dataIn,
        output dataOutValid, dataOut, dataWriteSuc
    );

endinterface

// File: rtl/lsb_load_extend.sv
// Combinational sign/zero extension of a raw Cache read according to funct3.
module lsb_load_extend
    import load_store_buffer_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rawData,
    output logic [31:0] extValue
);

    always_comb begin
        // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
        extValue = rawData;
        case (funct3)
            FUNCT3_B:  extValue = {{24{rawData[7]}}, rawData[7:0]};
            FUNCT3_H:  extValue = {{16{rawData[15]}}, rawData[15:0]};
            FUNCT3_BU: extValue = {24'b0, rawData[7:0]};
            FUNCT3_HU: extValue = {16'b0, rawData[15:0]};
            default:   extValue = rawData;
        endcase
    end

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue: captures operands from the CDB, issues the head entry
// to Cache one request at a time and reports load results and store completions.
module load_store_buffer
    import load_store_buffer_pkg::*;
#(
    parameter int ROB_WIDTH = 4,
    parameter int LSB_WIDTH = 3,
    parameter int LSB_SIZE  = 2 ** LSB_WIDTH
) (
    input  logic                 clkIn,
    input  logic                 resetIn,
    input  logic                 readyIn,
    input  logic                 clearIn,

    input  logic                 newValid,
    input  logic                 newIsStore,
    input  logic [2:0]           newFunct3,
    input  logic [ROB_WIDTH-1:0] newRobIndex,
    input  logic [11:0]          newOffset,
    input  logic                 newBaseValid,
    input  logic [31:0]          newBase,
    input  logic [ROB_WIDTH-1:0] newBaseTag,
    input  logic                 newDataValid,
    input  logic [31:0]          newData,
    input  logic [ROB_WIDTH-1:0] newDataTag,

    input  logic                 cdbValid,
    input  logic [ROB_WIDTH-1:0] cdbRobIndex,
    input  logic [31:0]          cdbValue,

    input  logic [ROB_WIDTH-1:0] robHeadIndex,
    output logic                 lsbFull,

    load_store_buffer_if.master  cache,

    output logic                 resultValid,
    output logic [ROB_WIDTH-1:0] resultRobIndex,
    output logic [31:0]          resultValue,
    output logic                 storeDoneValid,
    output logic [ROB_WIDTH-1:0] storeDoneRobIndex
);

    typedef struct packed {
        logic                 isStore;
        logic [2:0]           funct3;
        logic [ROB_WIDTH-1:0] robIndex;
        logic [11:0]          offset;
        logic                 baseReady;
        logic [31:0]          base;
        logic [ROB_WIDTH-1:0] baseTag;
        logic                 dataReady;
        logic [31:0]          data;
        logic [ROB_WIDTH-1:0] dataTag;
    } entry_t;

    localparam logic [LSB_WIDTH:0]   FULL_COUNT = (LSB_WIDTH + 1)'(LSB_SIZE);
    localparam logic [LSB_WIDTH:0]   COUNT_ONE  = 1;
    localparam logic [LSB_WIDTH-1:0] PTR_ONE    = 1;

    entry_t               entries [LSB_SIZE];
    logic [LSB_SIZE-1:0]  entryValid;
    logic [LSB_WIDTH-1:0] head;
    logic [LSB_WIDTH-1:0] tail;
    logic [LSB_WIDTH:0]   count;

    lsbState_e state;
    lsbState_e stateNext;

    logic [1:0]  accessTypeReg;
    logic        readWriteReg;
    logic [31:0] dataAddrReg;
    logic [31:0] dataReg;

    logic        doEnqueue;
    logic        doIssue;
    logic        doPop;
    logic [31:0] headAddr;
    logic        headInOrder;
    logic [31:0] loadValue;
    entry_t      newEntry;

    assign cache.accessType  = accessTypeReg;
    assign cache.readWriteIn = readWriteReg;
    assign cache.dataAddrIn  = dataAddrReg;
    assign cache.dataIn      = dataReg;

    assign lsbFull   = (count == FULL_COUNT);
    assign doEnqueue = newValid && !lsbFull;

    assign headAddr    = entries[head].base + {{20{entries[head].offset[11]}}, entries[head].offset};
    assign headInOrder = (entries[head].robIndex == robHeadIndex);

    lsb_load_extend loadExtend (
        .funct3   (entries[head].funct3),
        .rawData  (cache.dataOut),
        .extValue (loadValue)
    );

    // Operands still pending at enqueue may be satisfied by the CDB in the same cycle.
    always_comb begin
        newEntry          = '0;
        newEntry.isStore  = newIsStore;
        newEntry.funct3   = newFunct3;
        newEntry.robIndex = newRobIndex;
        newEntry.offset   = newOffset;
        newEntry.baseTag  = newBaseTag;
        newEntry.dataTag  = newDataTag;
        newEntry.baseReady = newBaseValid || (cdbValid && cdbRobIndex == newBaseTag);
        newEntry.base      = newBaseValid ? newBase : cdbValue;
        newEntry.dataReady = !newIsStore || newDataValid || (cdbValid && cdbRobIndex == newDataTag);
        newEntry.data      = newDataValid ? newData : cdbValue;
    end

    always_comb begin
        stateNext = state;
        doIssue   = 1'b0;
        doPop     = 1'b0;
        case (state)
            STATE_IDLE: begin
                // Stores and IO loads have side effects, so they wait until they are the ROB head.
                if (count != '0 && entries[head].baseReady && entries[head].dataReady &&
                    ((!entries[head].isStore && !isIoAddr(headAddr)) || headInOrder)) begin
                    doIssue   = 1'b1;
                    stateNext = STATE_WAIT;
                end
            end
            STATE_WAIT: begin
                if (entries[head].isStore ? cache.dataWriteSuc : cache.dataOutValid) begin
                    doPop     = 1'b1;
                    stateNext = STATE_IDLE;
                end
            end
            default: stateNext = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clkIn) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (resetIn) begin
            state <= STATE_IDLE;
        end else if (readyIn) begin
            state <= clearIn ? STATE_IDLE : stateNext;
        end
    end

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            entryValid        <= '0;
            accessTypeReg     <= ACCESS_NONE;
            readWriteReg      <= 1'b0;
            dataAddrReg       <= '0;
            dataReg           <= '0;
            resultValid       <= 1'b0;
            resultRobIndex    <= '0;
            resultValue       <= '0;
            storeDoneValid    <= 1'b0;
            storeDoneRobIndex <= '0;
        end else if (readyIn) begin
            if (clearIn) begin
                head           <= '0;
                tail           <= '0;
                count          <= '0;
                entryValid     <= '0;
                accessTypeReg  <= ACCESS_NONE;
                resultValid    <= 1'b0;
                storeDoneValid <= 1'b0;
            end else begin
                accessTypeReg  <= ACCESS_NONE;
                resultValid    <= 1'b0;
                storeDoneValid <= 1'b0;

                if (doIssue) begin
                    accessTypeReg <= entries[head].funct3[1:0] + 2'd1;
                    readWriteReg  <= ~entries[head].isStore;
                    dataAddrReg   <= headAddr;
                    dataReg       <= entries[head].data;
                end

                if (doPop) begin
                    if (entries[head].isStore) begin
                        storeDoneValid    <= 1'b1;
                        storeDoneRobIndex <= entries[head].robIndex;
                    end else begin
                        resultValid    <= 1'b1;
                        resultRobIndex <= entries[head].robIndex;
                        resultValue    <= loadValue;
                    end
                    entryValid[head] <= 1'b0;
                    head             <= head + PTR_ONE;
                end

                if (doEnqueue) begin
                    entryValid[tail] <= 1'b1;
                    tail             <= tail + PTR_ONE;
                end

                if (doEnqueue && !doPop) begin
                    count <= count + COUNT_ONE;
                end else if (doPop && !doEnqueue) begin
                    count <= count - COUNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clkIn) begin
        // NOTE: entry payloads have no reset; entryValid alone decides which slots are live.
        if (readyIn) begin
            for (int i = 0; i < LSB_SIZE; i++) begin
                if (entryValid[i]) begin
                    if (!entries[i].baseReady && cdbValid && cdbRobIndex == entries[i].baseTag) begin
                        entries[i].base      <= cdbValue;
                        entries[i].baseReady <= 1'b1;
                    end
                    if (!entries[i].dataReady && cdbValid && cdbRobIndex == entries[i].dataTag) begin
                        entries[i].data      <= cdbValue;
                        entries[i].dataReady <= 1'b1;
                    end
                end
            end
            if (doEnqueue) begin
                entries[tail] <= newEntry;
            end
        end
    end

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed bench for load_store_buffer with hand-computed expectations.
module tb_load_store_buffer;

    logic        clkIn = 1'b0;
    logic        resetIn, readyIn, clearIn;
    logic        newValid, newIsStore;
    logic [2:0]  newFunct3;
    logic [3:0]  newRobIndex;
    logic [11:0] newOffset;
    logic        newBaseValid;
    logic [31:0] newBase;
    logic [3:0]  newBaseTag;
    logic        newDataValid;
    logic [31:0] newData;
    logic [3:0]  newDataTag;
    logic        cdbValid;
    logic [3:0]  cdbRobIndex;
    logic [31:0] cdbValue;
    logic [3:0]  robHeadIndex;
    logic        lsbFull;
    logic        resultValid;
    logic [3:0]  resultRobIndex;
    logic [31:0] resultValue;
    logic        storeDoneValid;
    logic [3:0]  storeDoneRobIndex;

    int checks = 0;
    int errors = 0;

    always #5 clkIn = ~clkIn;

    load_store_buffer_if cacheBus ();

    load_store_buffer dut (
        .clkIn             (clkIn),
        .resetIn           (resetIn),
        .readyIn           (readyIn),
        .clearIn           (clearIn),
        .newValid          (newValid),
        .newIsStore        (newIsStore),
        .newFunct3         (newFunct3),
        .newRobIndex       (newRobIndex),
        .newOffset         (newOffset),
        .newBaseValid      (newBaseValid),
        .newBase           (newBase),
        .newBaseTag        (newBaseTag),
        .newDataValid      (newDataValid),
        .newData           (newData),
        .newDataTag        (newDataTag),
        .cdbValid          (cdbValid),
        .cdbRobIndex       (cdbRobIndex),
        .cdbValue          (cdbValue),
        .robHeadIndex      (robHeadIndex),
        .lsbFull           (lsbFull),
        .cache             (cacheBus.master),
        .resultValid       (resultValid),
        .resultRobIndex    (resultRobIndex),
        .resultValue       (resultValue),
        .storeDoneValid    (storeDoneValid),
        .storeDoneRobIndex (storeDoneRobIndex)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clkIn);
        #1;
    endtask

    task automatic setNew(input logic isStore, input logic [2:0] funct3, input logic [3:0] rob,
                          input logic [11:0] offset, input logic baseValid, input logic [31:0] base,
                          input logic [3:0] baseTag, input logic dataValid, input logic [31:0] data,
                          input logic [3:0] dataTag);
        newValid     = 1'b1;
        newIsStore   = isStore;
        newFunct3    = funct3;
        newRobIndex  = rob;
        newOffset    = offset;
        newBaseValid = baseValid;
        newBase      = base;
        newBaseTag   = baseTag;
        newDataValid = dataValid;
        newData      = data;
        newDataTag   = dataTag;
    endtask

    task automatic enqLoad(input logic [2:0] funct3, input logic [3:0] rob, input logic [31:0] base,
                           input logic [11:0] offset);
        setNew(1'b0, funct3, rob, offset, 1'b1, base, 4'd0, 1'b0, 32'd0, 4'd0);
        step();
        newValid = 1'b0;
    endtask

    task automatic waitIssue(input string tag);
        int n = 0;
        while (cacheBus.accessType == 2'b00 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_issued"}, 32'(cacheBus.accessType != 2'b00), 32'd1);
    endtask

    task automatic serveLoad(input string tag, input logic [1:0] expAccess, input logic [31:0] expAddr,
                             input logic [31:0] raw, input logic [31:0] expValue, input logic [3:0] expRob);
        waitIssue(tag);
        check({tag, "_access"}, 32'(cacheBus.accessType), 32'(expAccess));
        check({tag, "_addr"}, cacheBus.dataAddrIn, expAddr);
        check({tag, "_rw"}, 32'(cacheBus.readWriteIn), 32'd1);
        cacheBus.dataOutValid = 1'b1;
        cacheBus.dataOut      = raw;
        step();
        cacheBus.dataOutValid = 1'b0;
        check({tag, "_resvalid"}, 32'(resultValid), 32'd1);
        check({tag, "_value"}, resultValue, expValue);
        check({tag, "_rob"}, 32'(resultRobIndex), 32'(expRob));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetIn = 1'b1; readyIn = 1'b1; clearIn = 1'b0;
        newValid = 1'b0; newIsStore = 1'b0; newFunct3 = 3'd0; newRobIndex = 4'd0;
        newOffset = 12'd0; newBaseValid = 1'b0; newBase = 32'd0; newBaseTag = 4'd0;
        newDataValid = 1'b0; newData = 32'd0; newDataTag = 4'd0;
        cdbValid = 1'b0; cdbRobIndex = 4'd0; cdbValue = 32'd0; robHeadIndex = 4'd0;
        cacheBus.dataOutValid = 1'b0; cacheBus.dataOut = 32'd0; cacheBus.dataWriteSuc = 1'b0;
        step();
        step();
        check("reset_full", 32'(lsbFull), 32'd0);
        check("reset_access", 32'(cacheBus.accessType), 32'd0);
        check("reset_addr", cacheBus.dataAddrIn, 32'd0);
        check("reset_result", 32'(resultValid), 32'd0);
        check("reset_store", 32'(storeDoneValid), 32'd0);
        resetIn = 1'b0;
        step();

        // LW 0x100 + 4
        enqLoad(3'b010, 4'd1, 32'h100, 12'h004);
        serveLoad("lw", 2'b11, 32'h104, 32'hDEADBEEF, 32'hDEADBEEF, 4'd1);
        check("lw_access_drop", 32'(cacheBus.accessType), 32'd0);
        step();
        check("lw_pulse_end", 32'(resultValid), 32'd0);

        // LB then LBU, same address, program order
        enqLoad(3'b000, 4'd2, 32'h200, 12'h000);
        enqLoad(3'b100, 4'd3, 32'h200, 12'h000);
        serveLoad("lb", 2'b01, 32'h200, 32'h00000080, 32'hFFFFFF80, 4'd2);
        serveLoad("lbu", 2'b01, 32'h200, 32'h00000080, 32'h00000080, 4'd3);

        // SW with pending data tag 5, negative offset
        setNew(1'b1, 3'b010, 4'd6, 12'hFF0, 1'b1, 32'h400, 4'd0, 1'b0, 32'd0, 4'd5);
        step();
        newValid = 1'b0;
        step(); step(); step();
        check("sw_wait_data", 32'(cacheBus.accessType), 32'd0);
        cdbValid = 1'b1; cdbRobIndex = 4'd5; cdbValue = 32'h12345678;
        step();
        cdbValid = 1'b0;
        step(); step();
        check("sw_wait_head", 32'(cacheBus.accessType), 32'd0);
        robHeadIndex = 4'd6;
        waitIssue("sw");
        check("sw_access", 32'(cacheBus.accessType), 32'd3);
        check("sw_rw", 32'(cacheBus.readWriteIn), 32'd0);
        check("sw_addr", cacheBus.dataAddrIn, 32'h3F0);
        check("sw_data", cacheBus.dataIn, 32'h12345678);
        cacheBus.dataWriteSuc = 1'b1;
        step();
        cacheBus.dataWriteSuc = 1'b0;
        check("sw_done", 32'(storeDoneValid), 32'd1);
        check("sw_done_rob", 32'(storeDoneRobIndex), 32'd6);
        check("sw_no_result", 32'(resultValid), 32'd0);

        // SB whose data arrives on the CDB in the enqueue cycle
        robHeadIndex = 4'd7;
        setNew(1'b1, 3'b000, 4'd7, 12'h001, 1'b1, 32'h800, 4'd0, 1'b0, 32'd0, 4'd3);
        cdbValid = 1'b1; cdbRobIndex = 4'd3; cdbValue = 32'hA5A500C3;
        step();
        newValid = 1'b0; cdbValid = 1'b0;
        waitIssue("sb");
        check("sb_access", 32'(cacheBus.accessType), 32'd1);
        check("sb_addr", cacheBus.dataAddrIn, 32'h801);
        check("sb_data", cacheBus.dataIn, 32'hA5A500C3);
        cacheBus.dataWriteSuc = 1'b1;
        step();
        cacheBus.dataWriteSuc = 1'b0;
        check("sb_done_rob", 32'(storeDoneRobIndex), 32'd7);

        // IO load blocks a younger normal load until it is the ROB head
        robHeadIndex = 4'd0;
        enqLoad(3'b010, 4'd8, 32'h30000, 12'h000);
        enqLoad(3'b010, 4'd9, 32'h1000, 12'h000);
        step(); step(); step(); step();
        check("io_blocked", 32'(cacheBus.accessType), 32'd0);
        robHeadIndex = 4'd8;
        serveLoad("io", 2'b11, 32'h30000, 32'h11223344, 32'h11223344, 4'd8);
        serveLoad("behind_io", 2'b11, 32'h1000, 32'hCAFEF00D, 32'hCAFEF00D, 4'd9);

        // Fill with IO loads that cannot issue, pointers wrap
        robHeadIndex = 4'd15;
        for (int i = 0; i < 8; i++) begin
            enqLoad(3'b010, 4'(i), 32'h30000 + 32'(4 * i), 12'h000);
        end
        check("fill_full", 32'(lsbFull), 32'd1);
        enqLoad(3'b010, 4'd8, 32'h1000, 12'h000);
        check("ninth_full", 32'(lsbFull), 32'd1);
        robHeadIndex = 4'd0;
        waitIssue("full_pop0");
        check("full_pop0_addr", cacheBus.dataAddrIn, 32'h30000);
        setNew(1'b0, 3'b010, 4'd9, 12'h000, 1'b1, 32'h30040, 4'd0, 1'b0, 32'd0, 4'd0);
        cacheBus.dataOutValid = 1'b1; cacheBus.dataOut = 32'h0;
        step();
        newValid = 1'b0; cacheBus.dataOutValid = 1'b0;
        check("full_pop0_rob", 32'(resultRobIndex), 32'd0);
        check("full_enq_ignored", 32'(lsbFull), 32'd0);
        robHeadIndex = 4'd1;
        waitIssue("pop1");
        check("pop1_addr", cacheBus.dataAddrIn, 32'h30004);
        setNew(1'b0, 3'b010, 4'd10, 12'h000, 1'b1, 32'h30050, 4'd0, 1'b0, 32'd0, 4'd0);
        cacheBus.dataOutValid = 1'b1;
        step();
        newValid = 1'b0; cacheBus.dataOutValid = 1'b0;
        check("pop1_rob", 32'(resultRobIndex), 32'd1);
        check("pop_enq_count", 32'(lsbFull), 32'd0);
        enqLoad(3'b010, 4'd11, 32'h30060, 12'h000);
        check("refill_full", 32'(lsbFull), 32'd1);

        // Flush while a load is in WAIT, stale response ignored
        robHeadIndex = 4'd2;
        waitIssue("flush_load");
        check("flush_load_addr", cacheBus.dataAddrIn, 32'h30008);
        clearIn = 1'b1;
        step();
        clearIn = 1'b0;
        check("flush_access", 32'(cacheBus.accessType), 32'd0);
        check("flush_full", 32'(lsbFull), 32'd0);
        cacheBus.dataOutValid = 1'b1; cacheBus.dataOut = 32'h55555555;
        step();
        cacheBus.dataOutValid = 1'b0;
        check("stale_result", 32'(resultValid), 32'd0);
        step(); step();
        check("flush_empty", 32'(cacheBus.accessType), 32'd0);

        // Enqueue after flush lands at index 0; readyIn low freezes a pending response
        robHeadIndex = 4'd0;
        enqLoad(3'b001, 4'd13, 32'h600, 12'h002);
        check("post_flush_head", 32'(dut.head), 32'd0);
        check("post_flush_tail", 32'(dut.tail), 32'd1);
        waitIssue("lh");
        check("lh_access", 32'(cacheBus.accessType), 32'd2);
        check("lh_addr", cacheBus.dataAddrIn, 32'h602);
        readyIn = 1'b0;
        cacheBus.dataOutValid = 1'b1; cacheBus.dataOut = 32'h00018000;
        step(); step();
        check("frozen_result", 32'(resultValid), 32'd0);
        check("frozen_access", 32'(cacheBus.accessType), 32'd2);
        readyIn = 1'b1;
        step();
        cacheBus.dataOutValid = 1'b0;
        check("lh_value", resultValue, 32'hFFFF8000);
        check("lh_rob", 32'(resultRobIndex), 32'd13);
        enqLoad(3'b101, 4'd14, 32'h500, 12'h7FF);
        serveLoad("lhu", 2'b10, 32'h00000CFF, 32'hFFFF8001, 32'h00008001, 4'd14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
